// File: rtl/checkpointed_rename_table_pkg.sv
// Shared rename-stage types and constants.
package rename_pkg;
  localparam int unsigned ARCH_REG_NUM    = 32;
  localparam int unsigned AREG_W          = 5;
  localparam int unsigned PHY_REG_NUM_DEF = 64;
  localparam int unsigned PREG_W          = $clog2(PHY_REG_NUM_DEF);

  typedef logic [AREG_W-1:0]            ArchIdxT;
  // Default-configuration preg index and map types.
  typedef logic [PREG_W-1:0]            PregIdxT;
  typedef PregIdxT [ARCH_REG_NUM-1:0]   RatMapT;
endpackage

// File: rtl/checkpointed_rename_table_if.sv
// Rename-group, checkpoint-control and writeback bundle.
interface checkpointed_rename_table_if
  import rename_pkg::*;
#(
  parameter int unsigned PHY_REG_NUM  = 64,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned WB_WIDTH     = 4,
  parameter int unsigned CKPT_NUM     = 4
);
  localparam int unsigned P = $clog2(PHY_REG_NUM);
  localparam int unsigned C = $clog2(CKPT_NUM);

  logic    [DECODE_WIDTH-1:0]         rename_valid;
  logic    [DECODE_WIDTH-1:0]         dest_valid;
  ArchIdxT [DECODE_WIDTH-1:0]         src0;
  ArchIdxT [DECODE_WIDTH-1:0]         src1;
  ArchIdxT [DECODE_WIDTH-1:0]         dest;
  logic    [DECODE_WIDTH-1:0][P-1:0]  preg;
  logic    [DECODE_WIDTH-1:0]         ckpt_req;
  logic    [DECODE_WIDTH-1:0][P-1:0]  psrc0;
  logic    [DECODE_WIDTH-1:0][P-1:0]  psrc1;
  logic    [DECODE_WIDTH-1:0]         psrc0_ready;
  logic    [DECODE_WIDTH-1:0]         psrc1_ready;
  logic    [DECODE_WIDTH-1:0][P-1:0]  ppdst;
  logic    [C-1:0]                    ckpt_id;
  logic                               ckpt_full;
  logic                               ckpt_empty;
  logic                               ckpt_release;
  logic                               restore_ckpt;
  logic    [C-1:0]                    restore_id;
  logic                               restore_arch;
  logic    [ARCH_REG_NUM-1:0][P-1:0]  arch_map;
  logic    [WB_WIDTH-1:0]             wb;
  logic    [WB_WIDTH-1:0][P-1:0]      wb_pdest;

  modport master (
    output rename_valid, dest_valid, src0, src1, dest, preg, ckpt_req,
           ckpt_release, restore_ckpt, restore_id, restore_arch, arch_map,
           wb, wb_pdest,
    input  psrc0, psrc1, psrc0_ready, psrc1_ready, ppdst,
           ckpt_id, ckpt_full, ckpt_empty
  );

  modport slave (
    input  rename_valid, dest_valid, src0, src1, dest, preg, ckpt_req,
           ckpt_release, restore_ckpt, restore_id, restore_arch, arch_map,
           wb, wb_pdest,
    output psrc0, psrc1, psrc0_ready, psrc1_ready, ppdst,
           ckpt_id, ckpt_full, ckpt_empty
  );
endinterface

// File: rtl/checkpointed_rename_table_ckpt_buf.sv
// Circular buffer of map snapshots taken at branches.
module rat_checkpoint_buffer
  import rename_pkg::*;
#(
  parameter int unsigned PHY_REG_NUM = 64,
  parameter int unsigned CKPT_NUM    = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              flush,
  input  logic                                              restore,
  input  logic [$clog2(CKPT_NUM)-1:0]                       restore_id,
  input  logic                                              alloc,
  input  logic                                              release_oldest,
  input  logic [ARCH_REG_NUM-1:0][$clog2(PHY_REG_NUM)-1:0]  snap_wdata,
  output logic [ARCH_REG_NUM-1:0][$clog2(PHY_REG_NUM)-1:0]  snap_rdata,
  output logic [$clog2(CKPT_NUM)-1:0]                       tail,
  output logic                                              full,
  output logic                                              empty
);
  localparam int unsigned P = $clog2(PHY_REG_NUM);
  localparam int unsigned C = $clog2(CKPT_NUM);

  typedef logic [ARCH_REG_NUM-1:0][P-1:0] map_t;

  map_t         snap_q [CKPT_NUM];
  logic [C-1:0] head_q;
  logic [C-1:0] tail_q;
  logic [C:0]   count_q;

  // Pointer/occupancy update; a restore frees the restored slot and everything younger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (restore) begin
      tail_q  <= restore_id;
      head_q  <= head_q + C'(release_oldest);
      count_q <= {1'b0, restore_id - head_q} - (C+1)'(release_oldest);
    end else begin
      if (alloc)          tail_q <= tail_q + 1'b1;
      if (release_oldest) head_q <= head_q + 1'b1;
      count_q <= count_q + (C+1)'(alloc) - (C+1)'(release_oldest);
    end
  end

  // Snapshot storage; only live slots are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (alloc) snap_q[tail_q] <= snap_wdata;
  end

  assign snap_rdata = snap_q[restore_id];
  assign tail       = tail_q;
  assign full       = (count_q == (C+1)'(CKPT_NUM));
  assign empty      = (count_q == '0);

  a_release_not_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(release_oldest && empty && !flush));
  a_restore_live_id : assert property (@(posedge clk) disable iff (!rst_n)
    (restore && !flush) |-> ({1'b0, restore_id - head_q} < count_q));
  a_restore_release_not_head : assert property (@(posedge clk) disable iff (!rst_n)
    (restore && release_oldest && !flush) |-> (restore_id != head_q));
endmodule

// File: rtl/checkpointed_rename_table.sv
// Register alias table with intra-group bypass, ready table and branch checkpoints.
module checkpointed_rename_table
  import rename_pkg::*;
#(
  parameter int unsigned PHY_REG_NUM  = 64,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned WB_WIDTH     = 4,
  parameter int unsigned CKPT_NUM     = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  checkpointed_rename_table_if.slave bus
);
  localparam int unsigned P = $clog2(PHY_REG_NUM);
  localparam int unsigned C = $clog2(CKPT_NUM);

  typedef logic [ARCH_REG_NUM-1:0][P-1:0] map_t;

  map_t                    map_q;
  map_t                    map_n;
  map_t                    snap_wdata;
  map_t                    snap_rdata;
  map_t                    arch_clean;
  logic [PHY_REG_NUM-1:0]  ready_q;
  logic [PHY_REG_NUM-1:0]  ready_n;
  logic [PHY_REG_NUM-1:0]  avail;
  logic [DECODE_WIDTH-1:0] eff_wr;
  logic                    rename_en;
  logic                    ckpt_req_v;
  logic                    ckpt_alloc;
  logic [C-1:0]            ckpt_tail;
  logic                    ckpt_full;
  logic                    ckpt_empty;

  assign rename_en  = !bus.restore_arch && !bus.restore_ckpt;
  assign ckpt_alloc = rename_en && ckpt_req_v && (!ckpt_full || bus.ckpt_release);

  // Which slots actually write the map (r0 is never remapped).
  always_comb begin
    eff_wr = '0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++)
      eff_wr[i] = bus.rename_valid[i] && bus.dest_valid[i] && (bus.dest[i] != '0);
  end

  // Ready as seen this cycle: registered table plus same-cycle writebacks; preg 0 always ready.
  always_comb begin
    avail = ready_q;
    for (int unsigned k = 0; k < WB_WIDTH; k++)
      if (bus.wb[k]) avail[bus.wb_pdest[k]] = 1'b1;
    avail[0] = 1'b1;
  end

  // Lookup with RAW/WAW override from the youngest older slot writing the same register.
  always_comb begin
    bus.psrc0       = '0;
    bus.psrc1       = '0;
    bus.ppdst       = '0;
    bus.psrc0_ready = '0;
    bus.psrc1_ready = '0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      bus.psrc0[i]       = map_q[bus.src0[i]];
      bus.psrc1[i]       = map_q[bus.src1[i]];
      bus.ppdst[i]       = map_q[bus.dest[i]];
      bus.psrc0_ready[i] = avail[map_q[bus.src0[i]]];
      bus.psrc1_ready[i] = avail[map_q[bus.src1[i]]];
      for (int unsigned j = 0; j < i; j++) begin
        if (eff_wr[j] && (bus.dest[j] == bus.src0[i])) begin
          bus.psrc0[i]       = bus.preg[j];
          bus.psrc0_ready[i] = 1'b0;
        end
        if (eff_wr[j] && (bus.dest[j] == bus.src1[i])) begin
          bus.psrc1[i]       = bus.preg[j];
          bus.psrc1_ready[i] = 1'b0;
        end
        if (eff_wr[j] && (bus.dest[j] == bus.dest[i]))
          bus.ppdst[i] = bus.preg[j];
      end
    end
  end

  // Next map in slot order; the snapshot is the map right after the branch slot's own write.
  always_comb begin
    map_n      = map_q;
    snap_wdata = map_q;
    ckpt_req_v = 1'b0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      if (eff_wr[i]) map_n[bus.dest[i]] = bus.preg[i];
      if (bus.ckpt_req[i] && bus.rename_valid[i]) begin
        snap_wdata = map_n;
        ckpt_req_v = 1'b1;
      end
    end
  end

  // Next ready table: writebacks set, then allocations clear so allocate wins.
  always_comb begin
    ready_n = ready_q;
    for (int unsigned k = 0; k < WB_WIDTH; k++)
      if (bus.wb[k]) ready_n[bus.wb_pdest[k]] = 1'b1;
    if (rename_en)
      for (int unsigned i = 0; i < DECODE_WIDTH; i++)
        if (eff_wr[i]) ready_n[bus.preg[i]] = 1'b0;
    ready_n[0] = 1'b1;
  end

  // Committed map with r0 pinned to preg 0.
  always_comb begin
    arch_clean    = bus.arch_map;
    arch_clean[0] = '0;
  end

  // Map/ready state with flush > checkpoint restore > rename precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < ARCH_REG_NUM; r++) map_q[r] <= P'(r);
      ready_q <= '1;
    end else if (bus.restore_arch) begin
      map_q   <= arch_clean;
      ready_q <= '1;
    end else if (bus.restore_ckpt) begin
      map_q   <= snap_rdata;
      ready_q <= ready_n;
    end else begin
      map_q   <= map_n;
      ready_q <= ready_n;
    end
  end

  rat_checkpoint_buffer #(
    .PHY_REG_NUM (PHY_REG_NUM),
    .CKPT_NUM    (CKPT_NUM)
  ) u_ckpt (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (bus.restore_arch),
    .restore        (bus.restore_ckpt),
    .restore_id     (bus.restore_id),
    .alloc          (ckpt_alloc),
    .release_oldest (bus.ckpt_release),
    .snap_wdata     (snap_wdata),
    .snap_rdata     (snap_rdata),
    .tail           (ckpt_tail),
    .full           (ckpt_full),
    .empty          (ckpt_empty)
  );

  assign bus.ckpt_id    = ckpt_tail;
  assign bus.ckpt_full  = ckpt_full;
  assign bus.ckpt_empty = ckpt_empty;

  a_one_ckpt_req : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.ckpt_req));
  a_no_alloc_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(ckpt_req_v && ckpt_full && !bus.ckpt_release));
endmodule

// File: tb/tb_checkpointed_rename_table.sv
// Randomized bench for checkpointed_rename_table against a sequential rename model.
module tb_checkpointed_rename_table;
  import rename_pkg::*;

  localparam int unsigned PN  = 64;
  localparam int unsigned DW  = 2;
  localparam int unsigned WBN = 4;
  localparam int unsigned CN  = 4;
  localparam int unsigned P   = $clog2(PN);
  localparam int unsigned C   = $clog2(CN);

  logic        clk;
  logic        rst_n;
  int unsigned vec_cnt;
  int unsigned err_cnt;

  // Model: plain arrays for the map/ready table, a queue of live checkpoint ids oldest-first.
  int unsigned m_map  [ARCH_REG_NUM];
  bit          m_ready[PN];
  int unsigned m_snap [CN][ARCH_REG_NUM];
  int unsigned m_live [$];
  int unsigned m_tail;

  checkpointed_rename_table_if #(
    .PHY_REG_NUM (PN), .DECODE_WIDTH (DW), .WB_WIDTH (WBN), .CKPT_NUM (CN)
  ) rif ();

  checkpointed_rename_table #(
    .PHY_REG_NUM (PN), .DECODE_WIDTH (DW), .WB_WIDTH (WBN), .CKPT_NUM (CN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int unsigned r = 0; r < ARCH_REG_NUM; r++) m_map[r] = r;
    for (int unsigned p = 0; p < PN; p++) m_ready[p] = 1'b1;
    m_live.delete();
    m_tail = 0;
  endtask

  task automatic clear_inputs();
    rif.rename_valid = '0;
    rif.dest_valid   = '0;
    rif.src0         = '0;
    rif.src1         = '0;
    rif.dest         = '0;
    rif.preg         = '0;
    rif.ckpt_req     = '0;
    rif.ckpt_release = 1'b0;
    rif.restore_ckpt = 1'b0;
    rif.restore_id   = '0;
    rif.restore_arch = 1'b0;
    rif.arch_map     = '0;
    rif.wb           = '0;
    rif.wb_pdest     = '0;
  endtask

  function automatic bit avail(input int unsigned p);
    bit r;
    r = m_ready[p] || (p == 0);
    for (int unsigned k = 0; k < WBN; k++)
      if (rif.wb[k] && (rif.wb_pdest[k] == P'(p))) r = 1'b1;
    return r;
  endfunction

  // Called with inputs set at a falling edge: checks outputs, advances the model, ends at the next falling edge.
  task automatic step();
    int unsigned work[ARCH_REG_NUM];
    bit          grp [ARCH_REG_NUM];
    int unsigned snap_map[ARCH_REG_NUM];
    bit          snap_take;
    int unsigned s;
    int          idx;
    #1;
    work      = m_map;
    grp       = '{default: 1'b0};
    snap_map  = m_map;
    snap_take = 1'b0;
    for (int unsigned i = 0; i < DW; i++) begin
      s = rif.src0[i];
      check_eq($sformatf("psrc0[%0d]", i), 64'(rif.psrc0[i]), 64'(work[s]));
      check_eq($sformatf("psrc0_ready[%0d]", i), 64'(rif.psrc0_ready[i]),
               64'(grp[s] ? 1'b0 : avail(work[s])));
      s = rif.src1[i];
      check_eq($sformatf("psrc1[%0d]", i), 64'(rif.psrc1[i]), 64'(work[s]));
      check_eq($sformatf("psrc1_ready[%0d]", i), 64'(rif.psrc1_ready[i]),
               64'(grp[s] ? 1'b0 : avail(work[s])));
      s = rif.dest[i];
      check_eq($sformatf("ppdst[%0d]", i), 64'(rif.ppdst[i]), 64'(work[s]));
      if (rif.rename_valid[i] && rif.dest_valid[i] && s != 0) begin
        work[s] = rif.preg[i];
        grp[s]  = 1'b1;
      end
      if (rif.ckpt_req[i] && rif.rename_valid[i]) begin
        snap_take = 1'b1;
        snap_map  = work;
      end
    end
    check_eq("ckpt_id", 64'(rif.ckpt_id), 64'(m_tail));
    check_eq("ckpt_full", 64'(rif.ckpt_full), 64'(m_live.size() == CN));
    check_eq("ckpt_empty", 64'(rif.ckpt_empty), 64'(m_live.size() == 0));

    for (int unsigned k = 0; k < WBN; k++)
      if (rif.wb[k]) m_ready[rif.wb_pdest[k]] = 1'b1;
    if (rif.restore_arch) begin
      for (int unsigned r = 0; r < ARCH_REG_NUM; r++) m_map[r] = (r == 0) ? 0 : rif.arch_map[r];
      for (int unsigned p = 0; p < PN; p++) m_ready[p] = 1'b1;
      m_live.delete();
      m_tail = 0;
    end else if (rif.restore_ckpt) begin
      idx = 0;
      for (int i = 0; i < m_live.size(); i++)
        if (m_live[i] == rif.restore_id) idx = i;
      while (m_live.size() > idx) m_live.delete(m_live.size() - 1);
      m_map  = m_snap[rif.restore_id];
      m_tail = rif.restore_id;
      if (rif.ckpt_release) void'(m_live.pop_front());
    end else begin
      for (int unsigned i = 0; i < DW; i++)
        if (rif.rename_valid[i] && rif.dest_valid[i] && rif.dest[i] != 0) m_ready[rif.preg[i]] = 1'b0;
      m_map = work;
      if (rif.ckpt_release) void'(m_live.pop_front());
      if (snap_take) begin
        m_snap[m_tail] = snap_map;
        m_live.push_back(m_tail);
        m_tail = (m_tail + 1) % CN;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Read every architectural register through the lookup ports.
  task automatic dump_map();
    for (int unsigned k = 0; k < ARCH_REG_NUM / 4; k++) begin
      clear_inputs();
      rif.src0[0] = 5'(4*k);
      rif.src1[0] = 5'(4*k + 1);
      rif.src0[1] = 5'(4*k + 2);
      rif.src1[1] = 5'(4*k + 3);
      step();
    end
  endtask

  task automatic rand_cycle();
    int  idx;
    bit  rel;
    int unsigned slot;
    clear_inputs();
    idx = 0;
    for (int unsigned i = 0; i < DW; i++) begin
      rif.rename_valid[i] = ($urandom_range(0, 3) != 0);
      rif.dest_valid[i]   = ($urandom_range(0, 3) != 0);
      rif.src0[i]         = 5'($urandom_range(0, 7));
      rif.src1[i]         = 5'($urandom_range(0, 31));
      rif.dest[i]         = 5'($urandom_range(0, 7));
      rif.preg[i]         = P'($urandom_range(1, PN - 1));
    end
    for (int unsigned k = 0; k < WBN; k++) begin
      rif.wb[k]       = ($urandom_range(0, 1) != 0);
      rif.wb_pdest[k] = P'($urandom_range(0, PN - 1));
    end
    if (m_live.size() > 0 && $urandom_range(0, 7) == 0) begin
      idx = $urandom_range(0, m_live.size() - 1);
      rif.restore_ckpt = 1'b1;
      rif.restore_id   = C'(m_live[idx]);
    end
    rel = (m_live.size() > 0) && ($urandom_range(0, 3) == 0);
    if (rif.restore_ckpt && idx == 0) rel = 1'b0;
    rif.ckpt_release = rel;
    if ($urandom_range(0, 2) == 0 && (m_live.size() < CN || rel)) begin
      slot = $urandom_range(0, DW - 1);
      rif.ckpt_req[slot]     = 1'b1;
      rif.rename_valid[slot] = 1'b1;
    end
    if ($urandom_range(0, 39) == 0) begin
      rif.restore_arch = 1'b1;
      for (int unsigned r = 1; r < ARCH_REG_NUM; r++) rif.arch_map[r] = P'($urandom_range(1, PN - 1));
    end
    step();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);

    // Reset state outputs.
    rif.src0[0] = 5'd9;  rif.src1[0] = 5'd17; rif.src0[1] = 5'd30; rif.src1[1] = 5'd0;
    #1;
    check_eq("rst_psrc0", 64'(rif.psrc0[0]), 64'd9);
    check_eq("rst_psrc1", 64'(rif.psrc1[1]), 64'd0);
    check_eq("rst_ready", 64'({rif.psrc0_ready, rif.psrc1_ready}), 64'hF);
    check_eq("rst_empty", 64'(rif.ckpt_empty), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic rename r5,r6 -> r7 with preg 40.
    clear_inputs();
    rif.rename_valid[0] = 1'b1; rif.dest_valid[0] = 1'b1;
    rif.src0[0] = 5'd5; rif.src1[0] = 5'd6; rif.dest[0] = 5'd7; rif.preg[0] = P'(40);
    #1;
    check_eq("basic_psrc0", 64'(rif.psrc0[0]), 64'd5);
    check_eq("basic_psrc1", 64'(rif.psrc1[0]), 64'd6);
    check_eq("basic_ready", 64'({rif.psrc0_ready[0], rif.psrc1_ready[0]}), 64'd3);
    check_eq("basic_ppdst", 64'(rif.ppdst[0]), 64'd7);
    step();
    clear_inputs();
    rif.src0[0] = 5'd7;
    #1;
    check_eq("r7_psrc", 64'(rif.psrc0[0]), 64'd40);
    check_eq("r7_ready", 64'(rif.psrc0_ready[0]), 64'd0);
    step();

    // Same-cycle writeback bypass, then allocate beats writeback.
    clear_inputs();
    rif.src0[0] = 5'd7; rif.wb[2] = 1'b1; rif.wb_pdest[2] = P'(40);
    #1;
    check_eq("wb_bypass_ready", 64'(rif.psrc0_ready[0]), 64'd1);
    step();
    clear_inputs();
    rif.rename_valid[0] = 1'b1; rif.dest_valid[0] = 1'b1; rif.dest[0] = 5'd8; rif.preg[0] = P'(40);
    rif.wb[0] = 1'b1; rif.wb_pdest[0] = P'(40);
    step();
    clear_inputs();
    rif.src0[0] = 5'd8;
    #1;
    check_eq("alloc_wins_ready", 64'(rif.psrc0_ready[0]), 64'd0);
    step();

    // Intra-group RAW and WAW on r3.
    clear_inputs();
    rif.rename_valid = 2'b11; rif.dest_valid = 2'b11;
    rif.dest[0] = 5'd3; rif.preg[0] = P'(33);
    rif.src0[1] = 5'd3; rif.dest[1] = 5'd3; rif.preg[1] = P'(34);
    #1;
    check_eq("raw_psrc", 64'(rif.psrc0[1]), 64'd33);
    check_eq("raw_ready", 64'(rif.psrc0_ready[1]), 64'd0);
    check_eq("waw_ppdst", 64'(rif.ppdst[1]), 64'd33);
    step();
    clear_inputs();
    rif.src0[0] = 5'd3;
    #1;
    check_eq("r3_after", 64'(rif.psrc0[0]), 64'd34);
    step();

    // Fill all four checkpoints, rename further, then restore id 1.
    for (int unsigned n = 0; n < CN; n++) begin
      clear_inputs();
      rif.rename_valid[n % DW] = 1'b1; rif.dest_valid[n % DW] = 1'b1;
      rif.dest[n % DW] = 5'(10 + n); rif.preg[n % DW] = P'(50 + n);
      rif.ckpt_req[n % DW] = 1'b1;
      #1;
      check_eq("fill_ckpt_id", 64'(rif.ckpt_id), 64'(n));
      step();
    end
    check_eq("full_flag", 64'(rif.ckpt_full), 64'd1);
    check_eq("full_id_wrap", 64'(rif.ckpt_id), 64'd0);
    clear_inputs();
    rif.rename_valid = 2'b11; rif.dest_valid = 2'b11;
    rif.dest[0] = 5'd10; rif.preg[0] = P'(60);
    rif.dest[1] = 5'd11; rif.preg[1] = P'(61);
    step();
    clear_inputs();
    rif.restore_ckpt = 1'b1; rif.restore_id = C'(1);
    rif.rename_valid[0] = 1'b1; rif.dest_valid[0] = 1'b1; rif.dest[0] = 5'd12; rif.preg[0] = P'(62);
    step();
    check_eq("restore_tail", 64'(rif.ckpt_id), 64'd1);
    check_eq("restore_cnt1", 64'({rif.ckpt_full, rif.ckpt_empty}), 64'd0);
    clear_inputs();
    rif.src0[0] = 5'd10; rif.src1[0] = 5'd11; rif.src0[1] = 5'd12;
    #1;
    check_eq("restore_r10", 64'(rif.psrc0[0]), 64'd50);
    check_eq("restore_r11", 64'(rif.psrc1[0]), 64'd51);
    check_eq("restore_r12", 64'(rif.psrc0[1]), 64'd12);
    step();
    dump_map();
    clear_inputs();
    rif.ckpt_release = 1'b1;
    step();
    check_eq("release_empty", 64'(rif.ckpt_empty), 64'd1);

    // Full flush coinciding with a rename and a checkpoint request.
    clear_inputs();
    rif.rename_valid[0] = 1'b1; rif.dest_valid[0] = 1'b1; rif.dest[0] = 5'd4; rif.preg[0] = P'(20);
    rif.ckpt_req[0] = 1'b1;
    rif.restore_arch = 1'b1;
    for (int unsigned r = 1; r < ARCH_REG_NUM; r++) rif.arch_map[r] = P'($urandom_range(1, PN - 1));
    step();
    check_eq("flush_empty", 64'(rif.ckpt_empty), 64'd1);
    check_eq("flush_id", 64'(rif.ckpt_id), 64'd0);
    dump_map();

    // Random traffic, asynchronous reset mid-stream, more random traffic.
    repeat (1500) rand_cycle();
    clear_inputs();
    rif.src0[0] = 5'd9; rif.src1[0] = 5'd17; rif.src0[1] = 5'd30; rif.src1[1] = 5'd1; rif.dest[1] = 5'd6;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_psrc0_0", 64'(rif.psrc0[0]), 64'd9);
    check_eq("arst_psrc1_0", 64'(rif.psrc1[0]), 64'd17);
    check_eq("arst_psrc0_1", 64'(rif.psrc0[1]), 64'd30);
    check_eq("arst_psrc1_1", 64'(rif.psrc1[1]), 64'd1);
    check_eq("arst_ppdst_1", 64'(rif.ppdst[1]), 64'd6);
    check_eq("arst_ready", 64'({rif.psrc0_ready, rif.psrc1_ready}), 64'hF);
    check_eq("arst_ckpt_id", 64'(rif.ckpt_id), 64'd0);
    check_eq("arst_full", 64'(rif.ckpt_full), 64'd0);
    check_eq("arst_empty", 64'(rif.ckpt_empty), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dump_map();
    repeat (500) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
